rej_eta_sampler: RTL and testbench
==================================

Name: rej_eta_sampler

Overview:
- Downstream consumer of the SHAKE256 squeeze stage in the Dilithium key-generation datapath (ExpandS).
- Accepts one rate-sized squeeze block at a time and scans it nibble by nibble. Applies eta rejection sampling and streams 256 accepted coefficients, reduced mod Q, to the polynomial buffer.
- Requests a further squeeze block whenever the current block is exhausted before 256 coefficients are produced.

Parameters:
- RATE, 1088, squeeze block width in bits; 2*RATE/8 = 272 nibbles per block.
- ETA, 2, secret bound; only 2 and 4 are legal.
- N, 256, coefficients per polynomial.
- Q, 8380417, modulus for output representation.
- COEF_W, 23, output coefficient width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  level request to sample one polynomial
- blk_in  in  RATE  squeeze block; byte i = blk_in[8i+7:8i]
- blk_valid  in  1  blk_in valid
- blk_ready  out  1  sampler can latch a block
- coef_out  out  COEF_W  coefficient in [0, Q-1]
- coef_valid  out  1  coef_out valid
- coef_ready  in  1  downstream accepts coef_out
- busy  out  1  state is not IDLE and not DONE
- done  out  1  polynomial complete

Behaviour:
- Reset value of every output while reset=0: blk_ready=0, coef_valid=0, coef_out=0, busy=0, done=0. The FSM enters IDLE and all counters and the block register clear. The same clear applies if reset asserts mid-operation; no partial state survives.
- FSM states: IDLE, WAIT_BLK, SCAN, DONE.
- IDLE:
  - start=1 -> WAIT_BLK next cycle; coef_cnt is cleared to 0.
  - start=0 -> stay in IDLE.
- WAIT_BLK:
  - blk_ready=1, combinational from state.
  - On blk_valid&blk_ready, blk_in is latched into blk_reg, nib_ptr is set to 0, and the FSM goes to SCAN next cycle.
- SCAN, current nibble t = blk_reg[4*nib_ptr +: 4]:
  - Even nib_ptr selects the low nibble of a byte and is consumed before the high nibble.
  - ETA=2: accept if t<15; coef = 2 - (t mod 5).
  - ETA=4: accept if t<9; coef = 4 - t.
  - A negative coef is output as Q+coef; otherwise the coef is output unchanged.
  - coef_valid = accept, combinational. coef_out stays stable while coef_valid=1 and coef_ready=0.
  - Advance condition: reject, or (accept & coef_ready). Only then does nib_ptr increment; coef_cnt increments on each accepted handshake.
  - Throughput is one nibble per cycle.
- Exit from SCAN:
  - Accepted handshake with coef_cnt==N-1 -> DONE. This takes priority over block exhaustion.
  - Otherwise, advancing at nib_ptr==2*RATE/8-1 -> WAIT_BLK.
- DONE:
  - done=1, registered, from the first cycle in DONE.
  - start=0 -> IDLE.
- start asserted outside IDLE is ignored. blk_valid outside WAIT_BLK is ignored; blk_ready is 0 there.
- Leftover nibbles in a block after the 256th coefficient are discarded.
- Latency with coef_ready held high: the first coefficient can be valid in the cycle after the block handshake.

Optional Feature:
- Macro REJ_ETA_STATS_EN.
- Defined: adds output ports rej_cnt[15:0] (rejected nibbles) and blk_cnt[7:0] (blocks latched). Both clear on reset and on the IDLE->WAIT_BLK transition, saturate at all-ones, and hold their value in DONE.
- Undefined: these ports and their counters do not exist. Core behaviour is identical with or without the macro.

Decomposition:
- Shared package dilithium_pkg holds:
  - constants Q, N, SHAKE256_RATE=1088, SHAKE128_RATE=1344;
  - the coefficient width;
  - the sampler state encoding (IDLE=0, WAIT_BLK=1, SCAN=2, DONE=3).
- One natural sub-module, eta_nibble_map: purely combinational; maps (t, ETA) to (accept, coef_out mod Q).

Test Plan:
- Zero block, ETA=2, coef_ready=1: blk_in=0 -> 256 coefs of value 2 on 256 consecutive cycles. done=1 the cycle after the last handshake; blk_ready never reasserts.
- All-0xF block, ETA=2: coef_valid stays 0 for 272 cycles -> WAIT_BLK and blk_ready=1. A second zero block then yields 256 coefs of 2. With REJ_ETA_STATS_EN: rej_cnt=272, blk_cnt=2.
- Mapping, ETA=2, byte 0xE0: nibble 0 -> coef 2; nibble 0xE -> 14 mod 5 = 4 -> coef 8380415. Mapping, ETA=4: nibble 8 -> coef 8380413; nibble 9 -> rejected.
- Backpressure: coef_ready=0 for 5 cycles on an accepted nibble -> coef_valid and coef_out hold, nib_ptr is unchanged, no coefficient is lost or duplicated.
- Block spanning: first block with 200 accepted nibbles (all others 0xF) -> WAIT_BLK after 272 nibbles; second block supplies the remaining 56 coefs, then DONE. Dropping start -> IDLE, done=0.
- Reset mid-SCAN at coef_cnt=100: reset=0 -> all outputs 0 immediately. After release, start=1 restarts at coef_cnt=0 and blk_ready=1 in WAIT_BLK.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared Dilithium datapath definitions.
//   Q, N           : modulus and coefficients per polynomial
//   SHAKE*_RATE    : squeeze block widths in bits
//   COEF_W         : width of a coefficient reduced mod Q
//   sampler_state_e: rejection sampler FSM encoding
package dilithium_pkg;

  localparam int unsigned COEF_W        = 23;
  localparam logic [COEF_W-1:0] Q       = 23'd8380417;
  localparam int unsigned N             = 256;
  localparam int unsigned SHAKE256_RATE = 1088;
  localparam int unsigned SHAKE128_RATE = 1344;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_SCAN     = 2'd2,
    ST_DONE     = 2'd3
  } sampler_state_e;

endpackage

// File: rtl/eta_nibble_map.sv
// Combinational eta mapping of one 4-bit squeeze nibble.
//   t_i      : nibble under test
//   accept_o : nibble lies inside the acceptance range for ETA
//   coef_o   : eta - f(t) represented in [0, Q-1]
// ETA=2 accepts t<15 with coef 2-(t mod 5); ETA=4 accepts t<9 with coef 4-t.
// Any ETA other than 2 takes the ETA=4 mapping.
module eta_nibble_map
  import dilithium_pkg::*;
#(
  parameter int unsigned ETA = 2
) (
  input  logic [3:0]        t_i,
  output logic              accept_o,
  output logic [COEF_W-1:0] coef_o
);

  logic [3:0] rem;
  logic [3:0] mag;
  logic       neg;

  always_comb begin
    accept_o = 1'b0;
    rem      = '0;
    mag      = '0;
    neg      = 1'b0;
    if (ETA == 2) begin
      accept_o = (t_i < 4'd15);
      rem      = t_i % 4'd5;
      if (rem <= 4'd2) begin
        mag = 4'd2 - rem;
      end else begin
        neg = 1'b1;
        mag = rem - 4'd2;
      end
    end else begin
      accept_o = (t_i < 4'd9);
      if (t_i <= 4'd4) begin
        mag = 4'd4 - t_i;
      end else begin
        neg = 1'b1;
        mag = t_i - 4'd4;
      end
    end
    // Negative values wrap to Q - |coef| so the output is always in [0, Q-1].
    coef_o = neg ? (Q - COEF_W'(mag)) : COEF_W'(mag);
  end

endmodule

// File: rtl/rej_eta_sampler.sv
// Eta rejection sampler (Dilithium ExpandS) fed by SHAKE256 squeeze blocks.
// Scans each latched block nibble by nibble (low nibble of a byte first),
// streams N accepted coefficients mod Q and asks for more blocks as needed.
//   clk, reset        : clock, asynchronous active-low reset
//   start             : level request to sample one polynomial
//   blk_in/blk_valid  : squeeze block input; blk_ready while waiting for one
//   coef_out/valid    : coefficient stream, coef_ready is downstream accept
//   busy, done        : in WAIT_BLK/SCAN; polynomial complete
// Optional macro REJ_ETA_STATS_EN adds rej_cnt (rejected nibbles) and
// blk_cnt (blocks latched), saturating and cleared when a run starts.
module rej_eta_sampler
  import dilithium_pkg::*;
#(
  parameter int unsigned RATE = SHAKE256_RATE,
  parameter int unsigned ETA  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RATE-1:0]   blk_in,
  input  logic              blk_valid,
  output logic              blk_ready,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy,
`ifdef REJ_ETA_STATS_EN
  output logic [15:0]       rej_cnt,
  output logic [7:0]        blk_cnt,
`endif
  output logic              done
);

  localparam int unsigned NIBBLES = 2 * RATE / 8;
  localparam int unsigned NIB_W   = $clog2(NIBBLES + 1);
  localparam int unsigned CNT_W   = $clog2(N);

  sampler_state_e    state_q, state_d;
  logic [RATE-1:0]   blk_reg_q, blk_reg_d;
  logic [NIB_W-1:0]  nib_ptr_q, nib_ptr_d;
  logic [CNT_W-1:0]  coef_cnt_q, coef_cnt_d;
  logic              done_q, done_d;

  logic [3:0]        nib;
  logic              accept;
  logic [COEF_W-1:0] map_coef;
  logic              in_scan;
  logic              hs;
  logic              adv;

  assign nib = blk_reg_q[{nib_ptr_q, 2'b00} +: 4];

  eta_nibble_map #(.ETA(ETA)) u_map (
    .t_i      (nib),
    .accept_o (accept),
    .coef_o   (map_coef)
  );

  assign in_scan = (state_q == ST_SCAN);
  assign hs      = in_scan & accept & coef_ready;
  assign adv     = in_scan & (~accept | coef_ready);

  always_comb begin
    state_d    = state_q;
    blk_reg_d  = blk_reg_q;
    nib_ptr_d  = nib_ptr_q;
    coef_cnt_d = coef_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WAIT_BLK;
          coef_cnt_d = '0;
        end
      end
      ST_WAIT_BLK: begin
        if (blk_valid) begin
          blk_reg_d = blk_in;
          nib_ptr_d = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (adv) begin
          nib_ptr_d = nib_ptr_q + 1'b1;
          if (hs) coef_cnt_d = coef_cnt_q + 1'b1;
          // Completing the polynomial wins over running out of nibbles.
          if (hs && (coef_cnt_q == CNT_W'(N - 1))) begin
            state_d = ST_DONE;
          end else if (nib_ptr_q == NIB_W'(NIBBLES - 1)) begin
            state_d = ST_WAIT_BLK;
          end
        end
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      blk_reg_q  <= '0;
      nib_ptr_q  <= '0;
      coef_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_reg_q  <= blk_reg_d;
      nib_ptr_q  <= nib_ptr_d;
      coef_cnt_q <= coef_cnt_d;
      done_q     <= done_d;
    end
  end

  assign blk_ready  = (state_q == ST_WAIT_BLK);
  assign coef_valid = in_scan & accept;
  assign coef_out   = coef_valid ? map_coef : '0;
  assign busy       = (state_q == ST_WAIT_BLK) | in_scan;
  assign done       = done_q;

`ifdef REJ_ETA_STATS_EN
  logic [15:0] rej_cnt_q, rej_cnt_d;
  logic [7:0]  blk_cnt_q, blk_cnt_d;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    blk_cnt_d = blk_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      rej_cnt_d = '0;
      blk_cnt_d = '0;
    end else begin
      if (in_scan && !accept && (rej_cnt_q != '1)) rej_cnt_d = rej_cnt_q + 16'd1;
      if (blk_ready && blk_valid && (blk_cnt_q != '1)) blk_cnt_d = blk_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rej_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign rej_cnt = rej_cnt_q;
  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_rej_eta_sampler.sv
// Directed self-checking bench for rej_eta_sampler (ETA=2 and ETA=4 instances).
module tb_rej_eta_sampler;

  localparam int unsigned RATE = 1088;
  localparam int QM = 8380417;

  logic            clk;
  logic            reset;
  logic            start, blk_valid, blk_ready, coef_valid, coef_ready, busy, done;
  logic [RATE-1:0] blk_in;
  logic [22:0]     coef_out;
  logic            start4, blk_valid4, blk_ready4, coef_valid4, coef_ready4, busy4, done4;
  logic [RATE-1:0] blk_in4;
  logic [22:0]     coef_out4;
`ifdef REJ_ETA_STATS_EN
  logic [15:0]     rej_cnt, rej_cnt4;
  logic [7:0]      blk_cnt, blk_cnt4;
`endif

  rej_eta_sampler #(.RATE(RATE), .ETA(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .blk_in     (blk_in),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
`ifdef REJ_ETA_STATS_EN
    .rej_cnt    (rej_cnt),
    .blk_cnt    (blk_cnt),
`endif
    .done       (done)
  );

  rej_eta_sampler #(.RATE(RATE), .ETA(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .start      (start4),
    .blk_in     (blk_in4),
    .blk_valid  (blk_valid4),
    .blk_ready  (blk_ready4),
    .coef_out   (coef_out4),
    .coef_valid (coef_valid4),
    .coef_ready (coef_ready4),
    .busy       (busy4),
`ifdef REJ_ETA_STATS_EN
    .rej_cnt    (rej_cnt4),
    .blk_cnt    (blk_cnt4),
`endif
    .done       (done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int got_n, bad_n, cyc_n;
  logic [RATE-1:0] blk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hand table: coef = 2 - (t mod 5), negatives as Q + coef.
  function automatic int exp_eta2(input int t);
    case (t % 5)
      0:       return 2;
      1:       return 1;
      2:       return 0;
      3:       return QM - 1;
      default: return QM - 2;
    endcase
  endfunction

  // Consume coefficients until done, a block request, or the cycle budget.
  task automatic drain(input int max_cyc);
    cyc_n = 0;
    while (done !== 1'b1 && blk_ready !== 1'b1 && cyc_n < max_cyc) begin
      if (coef_valid === 1'b1) begin
        if (got_n >= exp_q.size() || coef_out !== 23'(exp_q[got_n])) bad_n++;
        got_n++;
      end
      tick();
      cyc_n++;
    end
  endtask

  task automatic load_twos();
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(2);
    got_n = 0;
    bad_n = 0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; blk_in = '0; blk_valid = 1'b0; coef_ready = 1'b1;
    start4 = 1'b0; blk_in4 = '0; blk_valid4 = 1'b0; coef_ready4 = 1'b0;
    #3;
    chk("rst_blk_ready", 32'(blk_ready), 0);
    chk("rst_coef_valid", 32'(coef_valid), 0);
    chk("rst_coef_out", 32'(coef_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_coef_out4", 32'(coef_out4), 0);
`ifdef REJ_ETA_STATS_EN
    chk("rst_rej_cnt", 32'(rej_cnt), 0);
    chk("rst_blk_cnt", 32'(blk_cnt), 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Zero block: 256 coefficients of 2 on consecutive cycles.
    load_twos();
    blk_in = '0; blk_valid = 1'b1; start = 1'b1;
    tick();
    chk("t1_wait_ready", 32'(blk_ready), 1);
    chk("t1_wait_busy", 32'(busy), 1);
    tick();
    blk_valid = 1'b0;
    chk("t1_first_valid", 32'(coef_valid), 1);
    drain(600);
    chk("t1_count", 32'(got_n), 256);
    chk("t1_cycles", 32'(cyc_n), 256);
    chk("t1_values", 32'(bad_n), 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_in_done", 32'(busy), 0);
    chk("t1_no_ready", 32'(blk_ready), 0);
    tick();
    chk("t1_done_hold", 32'(done), 1);
    start = 1'b0;
    tick();
    chk("t1_idle_done", 32'(done), 0);

    // All-0xF block is fully rejected, then a zero block completes the run.
    load_twos();
    blk_in = '1; blk_valid = 1'b1; start = 1'b1;
    tick();
    tick();
    blk_valid = 1'b0; blk_in = '0;
    drain(600);
    chk("t2_ff_cycles", 32'(cyc_n), 272);
    chk("t2_ff_none", 32'(got_n), 0);
    chk("t2_ff_ready", 32'(blk_ready), 1);
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    drain(600);
    chk("t2_count", 32'(got_n), 256);
    chk("t2_values", 32'(bad_n), 0);
    chk("t2_done", 32'(done), 1);
`ifdef REJ_ETA_STATS_EN
    chk("t2_rej_cnt", 32'(rej_cnt), 272);
    chk("t2_blk_cnt", 32'(blk_cnt), 2);
`endif
    start = 1'b0;
    tick();

    // Spanning two blocks with backpressure on the first coefficient.
    blk = '0;
    exp_q.delete();
    for (int i = 0; i < 272; i++) blk[4*i +: 4] = (i < 200) ? 4'(i % 15) : 4'hF;
    for (int i = 0; i < 200; i++) exp_q.push_back(exp_eta2(i % 15));
    for (int j = 0; j < 56; j++) exp_q.push_back(exp_eta2(j % 15));
    got_n = 0; bad_n = 0;
    blk_in = blk; blk_valid = 1'b1; start = 1'b1; coef_ready = 1'b0;
    tick();
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(coef_valid), 1);
      chk("t3_hold_out", 32'(coef_out), 2);
      tick();
    end
    coef_ready = 1'b1;
    drain(600);
    chk("t3_a_count", 32'(got_n), 200);
    chk("t3_a_cycles", 32'(cyc_n), 272);
    chk("t3_a_ready", 32'(blk_ready), 1);
    blk = '0;
    for (int j = 0; j < 272; j++) blk[4*j +: 4] = 4'(j % 15);
    blk_in = blk; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    drain(600);
    chk("t3_b_cycles", 32'(cyc_n), 56);
    chk("t3_count", 32'(got_n), 256);
    chk("t3_values", 32'(bad_n), 0);
    chk("t3_done", 32'(done), 1);
    chk("t3_no_ready", 32'(blk_ready), 0);
    start = 1'b0;
    tick();
    chk("t3_idle_done", 32'(done), 0);
    chk("t3_idle_busy", 32'(busy), 0);

    // ETA=4 mapping: nibbles 8, 9, 0, 4, 3.
    blk = '0;
    blk[3:0] = 4'd8; blk[7:4] = 4'd9; blk[11:8] = 4'd0; blk[15:12] = 4'd4; blk[19:16] = 4'd3;
    blk_in4 = blk; blk_valid4 = 1'b1; start4 = 1'b1; coef_ready4 = 1'b0;
    tick();
    tick();
    blk_valid4 = 1'b0;
    chk("e4_n8_valid", 32'(coef_valid4), 1);
    chk("e4_n8_out", 32'(coef_out4), 8380413);
    coef_ready4 = 1'b1;
    tick();
    chk("e4_n9_reject", 32'(coef_valid4), 0);
    tick();
    chk("e4_n0_out", 32'(coef_out4), 4);
    tick();
    chk("e4_n4_valid", 32'(coef_valid4), 1);
    chk("e4_n4_out", 32'(coef_out4), 0);
    tick();
    chk("e4_n3_out", 32'(coef_out4), 1);
    start4 = 1'b0;

    // ETA=2 byte 0xE0, then reset asserted at coef_cnt=100.
    blk = '0;
    blk[7:0] = 8'hE0;
    blk_in = blk; blk_valid = 1'b1; start = 1'b1; coef_ready = 1'b1;
    tick();
    tick();
    blk_valid = 1'b0;
    chk("m2_nib0", 32'(coef_out), 2);
    tick();
    chk("m2_nibE", 32'(coef_out), 8380415);
    repeat (99) tick();
    chk("r_pre_valid", 32'(coef_valid), 1);
    chk("r_pre_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("r_blk_ready", 32'(blk_ready), 0);
    chk("r_coef_valid", 32'(coef_valid), 0);
    chk("r_coef_out", 32'(coef_out), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_done", 32'(done), 0);
    #1;
    reset = 1'b1;
    load_twos();
    blk_in = '0;
    tick();
    chk("r_wait_ready", 32'(blk_ready), 1);
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    drain(600);
    chk("r_count", 32'(got_n), 256);
    chk("r_cycles", 32'(cyc_n), 256);
    chk("r_values", 32'(bad_n), 0);
    chk("r_done_after", 32'(done), 1);
    start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
